// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode/EX/MEM hazard sources in, pipeline hold/kill/redirect controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_p0_addr;
    logic [3:0]  id_p1_addr;
    logic        id_p0_used;
    logic        id_p1_used;
    logic [3:0]  id_dst_addr;
    logic        id_we;
    logic        id_mem_re;
    logic        id_jump;
    logic        id_bad_instr;
    logic        ex_mispredict;
    logic        mem_busy;

    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  pc_sel;
    logic        mode_set_valid;
    logic [1:0]  mode_set;
    logic        trap_active;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_valid, id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
        output id_dst_addr, id_we, id_mem_re, id_jump, id_bad_instr,
        output ex_mispredict, mem_busy,
        input  stall_if, stall_id, flush_id, flush_ex, pc_sel,
        input  mode_set_valid, mode_set, trap_active, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
        input  id_dst_addr, id_we, id_mem_re, id_jump, id_bad_instr,
        input  ex_mispredict, mem_busy,
        output stall_if, stall_id, flush_id, flush_ex, pc_sel,
        output mode_set_valid, mode_set, trap_active, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: mispredict/mem-busy/trap/load-use/jump resolution with trap drain FSM.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("hazard_ctrl: DRAIN_CYCLES must be in 1..15");
    end

    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES);
    localparam logic [1:0] PcSeq     = 2'd0;
    localparam logic [1:0] PcJump    = 2'd1;
    localparam logic [1:0] PcBranch  = 2'd2;
    localparam logic [1:0] PcTrap    = 2'd3;
    localparam logic [1:0] ModeTrap  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StTrapDrain,
        StTrapRedir
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ld_valid_q, ld_valid_d;
    logic [3:0] ld_dst_q, ld_dst_d;

    logic       stall_if_c;
    logic       stall_id_c;
    logic       flush_id_c;
    logic       flush_ex_c;
    logic [1:0] pc_sel_c;
    logic       mode_set_valid_c;
    logic [1:0] mode_set_c;
    logic       trap_active_c;
    logic       load_use;

    // r0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = ld_valid_q && (ld_dst_q != 4'd0) && hz.id_valid &&
                   ((hz.id_p0_used && (hz.id_p0_addr == ld_dst_q)) ||
                    (hz.id_p1_used && (hz.id_p1_addr == ld_dst_q)));
    end

    always_comb begin
        stall_if_c       = 1'b0;
        stall_id_c       = 1'b0;
        flush_id_c       = 1'b0;
        flush_ex_c       = 1'b0;
        pc_sel_c         = PcSeq;
        mode_set_valid_c = 1'b0;
        mode_set_c       = 2'b00;
        trap_active_c    = 1'b0;
        state_d          = state_q;
        cnt_d            = cnt_q;

        if (hz.ex_mispredict) begin
            // Branch correction overrides everything, including a trap in progress.
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
            pc_sel_c   = PcBranch;
            state_d    = StIdle;
            cnt_d      = 4'd0;
        end else if (hz.mem_busy) begin
            stall_if_c    = 1'b1;
            stall_id_c    = 1'b1;
            trap_active_c = (state_q != StIdle);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hz.id_valid && hz.id_bad_instr) begin
                        stall_if_c = 1'b1;
                        stall_id_c = 1'b1;
                        flush_ex_c = 1'b1;
                        cnt_d      = DrainLoad;
                        state_d    = StTrapDrain;
                    end else if (load_use) begin
                        stall_if_c = 1'b1;
                        stall_id_c = 1'b1;
                        flush_ex_c = 1'b1;
                    end else if (hz.id_valid && hz.id_jump) begin
                        pc_sel_c   = PcJump;
                        flush_id_c = 1'b1;
                    end
                end
                StTrapDrain: begin
                    stall_if_c    = 1'b1;
                    stall_id_c    = 1'b1;
                    flush_ex_c    = 1'b1;
                    trap_active_c = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = StTrapRedir;
                    end
                end
                StTrapRedir: begin
                    pc_sel_c         = PcTrap;
                    flush_id_c       = 1'b1;
                    mode_set_valid_c = 1'b1;
                    mode_set_c       = ModeTrap;
                    trap_active_c    = 1'b1;
                    state_d          = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Scoreboard follows the instruction leaving ID; a mem_busy hold keeps it intact.
    always_comb begin
        ld_valid_d = 1'b0;
        ld_dst_d   = ld_dst_q;
        if (hz.ex_mispredict) begin
            ld_valid_d = 1'b0;
        end else if (!stall_id_c) begin
            ld_valid_d = hz.id_valid && hz.id_mem_re && hz.id_we;
            ld_dst_d   = hz.id_dst_addr;
        end else if (hz.mem_busy) begin
            ld_valid_d = ld_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            ld_valid_q <= 1'b0;
            ld_dst_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_valid_q <= ld_valid_d;
            ld_dst_q   <= ld_dst_d;
        end
    end

    assign hz.stall_if       = stall_if_c & ~rst;
    assign hz.stall_id       = stall_id_c & ~rst;
    assign hz.flush_id       = flush_id_c & ~rst;
    assign hz.flush_ex       = flush_ex_c & ~rst;
    assign hz.pc_sel         = rst ? PcSeq : pc_sel_c;
    assign hz.mode_set_valid = mode_set_valid_c & ~rst;
    assign hz.mode_set       = rst ? 2'b00 : mode_set_c;
    assign hz.trap_active    = trap_active_c & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall_id_c && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if ((flush_id_c || flush_ex_c) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 16'd0;
    assign hz.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-scenario tasks with a queue of hand-derived expectations.
// Counter expectations depend on whether HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam int unsigned DRAIN = 2;

    // Output vector: {stall_if, stall_id, flush_id, flush_ex, pc_sel[1:0], msv, mode_set[1:0], trap}
    localparam logic [9:0] E_NONE  = 10'b0000_00_0_00_0;
    localparam logic [9:0] E_STALL = 10'b1100_00_0_00_0;
    localparam logic [9:0] E_LU    = 10'b1101_00_0_00_0;
    localparam logic [9:0] E_DRAIN = 10'b1101_00_0_00_1;
    localparam logic [9:0] E_BTRAP = 10'b1100_00_0_00_1;
    localparam logic [9:0] E_REDIR = 10'b0010_11_1_10_1;
    localparam logic [9:0] E_MISP  = 10'b0011_10_0_00_0;
    localparam logic [9:0] E_JUMP  = 10'b0010_01_0_00_0;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] p0;
        logic       u0;
        logic [3:0] p1;
        logic       u1;
        logic [3:0] dst;
        logic       we;
        logic       re;
        logic       jump;
        logic       bad;
        logic       misp;
        logic       busy;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    hazard_ctrl_if hz();

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0]  exp_q[$];
    logic [31:0] cnt_exp_q[$];
    logic [9:0]  obs;

    assign obs = {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex, hz.pc_sel,
                  hz.mode_set_valid, hz.mode_set, hz.trap_active};

    function automatic stim_t nop_op();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ld_op(input logic [3:0] dst);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.dst   = dst;
        s.we    = 1'b1;
        s.re    = 1'b1;
        return s;
    endfunction

    function automatic stim_t rd_op(input logic [3:0] p0, input logic u0,
                                    input logic [3:0] p1, input logic u1);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.p0    = p0;
        s.u0    = u0;
        s.p1    = p1;
        s.u1    = u1;
        return s;
    endfunction

    function automatic stim_t bad_op();
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.bad   = 1'b1;
        return s;
    endfunction

    function automatic stim_t jmp_op();
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.jump  = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst              = s.rst;
        hz.id_valid      = s.valid;
        hz.id_p0_addr    = s.p0;
        hz.id_p0_used    = s.u0;
        hz.id_p1_addr    = s.p1;
        hz.id_p1_used    = s.u1;
        hz.id_dst_addr   = s.dst;
        hz.id_we         = s.we;
        hz.id_mem_re     = s.re;
        hz.id_jump       = s.jump;
        hz.id_bad_instr  = s.bad;
        hz.ex_mispredict = s.misp;
        hz.mem_busy      = s.busy;
    endtask

    task automatic test_reset();
        stim_t s[4];
        logic [9:0] e[4];
        logic [9:0] want;
        s[0] = bad_op(); s[0].rst = 1'b1; s[0].jump = 1'b1; s[0].misp = 1'b1; e[0] = E_NONE;
        s[1] = s[0]; s[1].busy = 1'b1;                                          e[1] = E_NONE;
        s[2] = nop_op();                                                        e[2] = E_NONE;
        s[3] = jmp_op();                                                        e[3] = E_JUMP;
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset step %0d: got %b, expected %b", i, obs, want);
            end
            if (i == 1) begin
                checks++;
                if ({hz.stall_cnt, hz.flush_cnt} !== 32'd0) begin
                    errors++;
                    $display("FAIL reset counters: got %h/%h, expected 0/0",
                             hz.stall_cnt, hz.flush_cnt);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[14];
        logic [9:0] e[14];
        logic [9:0] want;
        s[0]  = ld_op(4'd3);                       e[0]  = E_NONE;
        s[1]  = rd_op(4'd1, 1'b1, 4'd3, 1'b1);     e[1]  = E_LU;
        s[2]  = s[1];                              e[2]  = E_NONE;
        s[3]  = ld_op(4'd0);                       e[3]  = E_NONE;
        s[4]  = rd_op(4'd0, 1'b1, 4'd0, 1'b1);     e[4]  = E_NONE;
        s[5]  = ld_op(4'd5);                       e[5]  = E_NONE;
        s[6]  = rd_op(4'd5, 1'b0, 4'd5, 1'b0);     e[6]  = E_NONE;
        s[7]  = ld_op(4'd7);                       e[7]  = E_NONE;
        s[8]  = rd_op(4'd7, 1'b1, 4'd7, 1'b1); s[8].valid = 1'b0; e[8] = E_NONE;
        s[9]  = ld_op(4'd9); s[9].we = 1'b0;       e[9]  = E_NONE;
        s[10] = rd_op(4'd9, 1'b1, 4'd0, 1'b0);     e[10] = E_NONE;
        s[11] = ld_op(4'd2);                       e[11] = E_NONE;
        s[12] = rd_op(4'd2, 1'b1, 4'd8, 1'b1);     e[12] = E_LU;
        s[13] = s[12];                             e[13] = E_NONE;
        for (int i = 0; i < 14; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL load_use step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        stim_t s[3];
        logic [9:0] e[3];
        logic [9:0] want;
        s[0] = jmp_op();                     e[0] = E_JUMP;
        s[1] = jmp_op(); s[1].valid = 1'b0;  e[1] = E_NONE;
        s[2] = nop_op();                     e[2] = E_NONE;
        for (int i = 0; i < 3; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL jump step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_trap();
        stim_t s[6];
        logic [9:0] e[6];
        logic [9:0] want;
        s[0] = bad_op();                     e[0] = E_LU;
        s[1] = bad_op(); s[1].jump = 1'b1;   e[1] = E_DRAIN;
        s[2] = s[1];                         e[2] = E_DRAIN;
        s[3] = s[1];                         e[3] = E_REDIR;
        s[4] = nop_op();                     e[4] = E_NONE;
        s[5] = bad_op(); s[5].valid = 1'b0;  e[5] = E_NONE;
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL trap step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mispredict();
        stim_t s[16];
        logic [9:0] e[16];
        logic [9:0] want;
        s[0]  = bad_op();                                     e[0]  = E_LU;
        s[1]  = nop_op();                                     e[1]  = E_DRAIN;
        s[2]  = nop_op(); s[2].misp = 1'b1;                   e[2]  = E_MISP;
        s[3]  = nop_op();                                     e[3]  = E_NONE;
        s[4]  = jmp_op();                                     e[4]  = E_JUMP;
        s[5]  = ld_op(4'd4);                                  e[5]  = E_NONE;
        s[6]  = rd_op(4'd4, 1'b1, 4'd0, 1'b0); s[6].misp = 1'b1; e[6] = E_MISP;
        s[7]  = rd_op(4'd4, 1'b1, 4'd0, 1'b0);                e[7]  = E_NONE;
        s[8]  = ld_op(4'd4);                                  e[8]  = E_NONE;
        s[9]  = bad_op();                                     e[9]  = E_LU;
        s[10] = nop_op();                                     e[10] = E_DRAIN;
        s[11] = nop_op();                                     e[11] = E_DRAIN;
        s[12] = nop_op(); s[12].misp = 1'b1;                  e[12] = E_MISP;
        s[13] = nop_op();                                     e[13] = E_NONE;
        s[14] = nop_op(); s[14].misp = 1'b1; s[14].busy = 1'b1; e[14] = E_MISP;
        s[15] = nop_op();                                     e[15] = E_NONE;
        for (int i = 0; i < 16; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mispredict step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_busy();
        stim_t s[15];
        logic [9:0] e[15];
        logic [9:0] want;
        s[0]  = ld_op(4'd6);                                  e[0]  = E_NONE;
        s[1]  = rd_op(4'd6, 1'b1, 4'd0, 1'b0); s[1].jump = 1'b1; s[1].busy = 1'b1;
        e[1]  = E_STALL;
        s[2]  = s[1];                                         e[2]  = E_STALL;
        s[3]  = s[1]; s[3].busy = 1'b0;                       e[3]  = E_LU;
        s[4]  = s[3];                                         e[4]  = E_JUMP;
        s[5]  = nop_op();                                     e[5]  = E_NONE;
        s[6]  = bad_op();                                     e[6]  = E_LU;
        s[7]  = nop_op(); s[7].busy = 1'b1;                   e[7]  = E_BTRAP;
        s[8]  = nop_op();                                     e[8]  = E_DRAIN;
        s[9]  = nop_op();                                     e[9]  = E_DRAIN;
        s[10] = nop_op(); s[10].busy = 1'b1;                  e[10] = E_BTRAP;
        s[11] = nop_op();                                     e[11] = E_REDIR;
        s[12] = nop_op();                                     e[12] = E_NONE;
        s[13] = bad_op(); s[13].busy = 1'b1;                  e[13] = E_STALL;
        s[14] = nop_op();                                     e[14] = E_NONE;
        for (int i = 0; i < 15; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mem_busy step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rst_mid_trap();
        stim_t s[7];
        logic [9:0] e[7];
        logic [9:0] want;
        s[0] = bad_op();                     e[0] = E_LU;
        s[1] = bad_op();                     e[1] = E_DRAIN;
        s[2] = bad_op(); s[2].rst = 1'b1;    e[2] = E_NONE;
        s[3] = nop_op(); s[3].rst = 1'b1;    e[3] = E_NONE;
        s[4] = nop_op();                     e[4] = E_NONE;
        s[5] = nop_op();                     e[5] = E_NONE;
        s[6] = jmp_op();                     e[6] = E_JUMP;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL rst_mid_trap step %0d: got %b, expected %b", i, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_perf_cnt();
        stim_t s;
        logic [31:0] want;
        s = nop_op(); s.rst = 1'b1;
        apply(s);
        @(posedge clk); #1;
        s = nop_op(); s.busy = 1'b1;
        apply(s);
        repeat (3) begin @(posedge clk); #1; end
        s = nop_op(); s.misp = 1'b1;
        apply(s);
        @(posedge clk); #1;
        apply(bad_op());
        @(posedge clk); #1;
        apply(nop_op());
        repeat (3) begin @(posedge clk); #1; end
`ifdef HAZARD_PERF_CNT_EN
        cnt_exp_q.push_back({16'd6, 16'd5});
`else
        cnt_exp_q.push_back(32'd0);
`endif
        want = cnt_exp_q.pop_front();
        checks++;
        if ({hz.stall_cnt, hz.flush_cnt} !== want) begin
            errors++;
            $display("FAIL perf_count: got %h/%h, expected %h/%h",
                     hz.stall_cnt, hz.flush_cnt, want[31:16], want[15:0]);
        end

        s = nop_op(); s.busy = 1'b1;
        apply(s);
        repeat (65535) @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        cnt_exp_q.push_back({16'hFFFF, 16'd5});
`else
        cnt_exp_q.push_back(32'd0);
`endif
        want = cnt_exp_q.pop_front();
        checks++;
        if ({hz.stall_cnt, hz.flush_cnt} !== want) begin
            errors++;
            $display("FAIL perf_saturate: got %h/%h, expected %h/%h",
                     hz.stall_cnt, hz.flush_cnt, want[31:16], want[15:0]);
        end

        s = nop_op(); s.misp = 1'b1;
        apply(s);
        repeat (2) begin @(posedge clk); #1; end
        s = nop_op(); s.busy = 1'b1;
        apply(s);
        repeat (3) begin @(posedge clk); #1; end
        apply(nop_op());
`ifdef HAZARD_PERF_CNT_EN
        cnt_exp_q.push_back({16'hFFFF, 16'd7});
`else
        cnt_exp_q.push_back(32'd0);
`endif
        want = cnt_exp_q.pop_front();
        checks++;
        if ({hz.stall_cnt, hz.flush_cnt} !== want) begin
            errors++;
            $display("FAIL perf_hold: got %h/%h, expected %h/%h",
                     hz.stall_cnt, hz.flush_cnt, want[31:16], want[15:0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: summary not reached by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_jump();
        test_trap();
        test_mispredict();
        test_mem_busy();
        test_rst_mid_trap();
        test_perf_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
